// File: rtl/cpu_pkg.sv
// Shared fetch-path types and constants: fetch entry layout, bubble word, reset PC.
// Pure declarations; no timing or flow-control behaviour.
package cpu_pkg;

    localparam int                INST_W           = 32;
    localparam logic [INST_W-1:0] NOP_BUBBLE       = 32'h0;
    localparam logic [31:0]       RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch queue of fetch entries; push visible at head next cycle, head is combinational.
// No internal backpressure: the owner's credit scheme prevents overflow; flush beats push and pop.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_dat,
    input  logic         pop,
    input  logic         flush,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop_ok;
    logic          push_ok;

    // Guards make the queue safe on its own even if a caller misbehaves.
    assign pop_ok  = pop && (count_q != '0);
    assign push_ok = push && ((int'(count_q) < DEPTH) || pop_ok);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_ptr_q] <= push_dat;
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited imem requests, queues responses for decode (grant->inst_valid 2 cycles).
// Decode stall holds the queue head; requests stop once queued + in-flight reaches DEPTH; a redirect flushes and drops stale responses.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              jump_flag,
    input  logic [31:0]       jump_target,
    input  logic              stall,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [31:0]       inst_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count;
    logic [31:0]   redirect_pc;
    logic          credit_ok;
    logic          accept;
    logic          push;
    logic          pop;
    fetch_entry_t  push_dat;
    fetch_entry_t  head;

    assign redirect_pc = jump_target & 32'hFFFF_FFFC;

    // In-flight fetches hold a queue slot in advance, so a kept response can always be pushed.
    assign credit_ok = (int'(outst_q) + int'(count)) < DEPTH;
    assign imem_req  = !reset && !jump_flag && credit_ok;
    assign imem_addr = fetch_pc_q;
    assign accept    = imem_req && imem_gnt;

    assign push     = imem_rvalid && !jump_flag && (discard_q == '0);
    assign pop      = inst_valid && !stall && !jump_flag;
    assign push_dat = '{pc: resp_pc_q, inst: imem_rdata};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        outst_d    = outst_q;
        discard_d  = discard_q;
        if (jump_flag) begin
            // Everything still in flight after this cycle belongs to the old path.
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            outst_d    = outst_q - CW'(imem_rvalid);
            discard_d  = outst_q - CW'(imem_rvalid);
        end else begin
            if (accept) fetch_pc_d = pc_next(fetch_pc_q);
            outst_d = outst_q + CW'(accept) - CW'(imem_rvalid);
            if (imem_rvalid) begin
                if (discard_q != '0) discard_d = discard_q - 1'b1;
                else                 resp_pc_d = pc_next(resp_pc_q);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .flush    (jump_flag),
        .count    (count),
        .head     (head)
    );

    assign inst_valid = (count != '0);
    assign inst       = inst_valid ? head.inst : NOP_BUBBLE;
    assign inst_pc    = inst_valid ? head.pc   : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with an in-order variable-latency memory model.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        jump_flag;
    logic [31:0] jump_target;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .jump_flag   (jump_flag),
        .jump_target (jump_target),
        .stall       (stall),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          cyc;
    } mreq_t;

    int           n_checks = 0;
    int           n_fail   = 0;
    fetch_entry_t exp_q[$];
    mreq_t        mem_q[$];
    logic [31:0]  next_pc;
    int           cyc;
    int           gnt_pct, stall_pct, rsp_pct, jmp_pct;
    bit           mem_hold;
    bit           hold_pending;
    logic [31:0]  hold_addr;
    int           first_acc, first_val;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs at negedge, then update the reference model from what the handshake did.
    task automatic step(input logic jmp, input logic [31:0] tgt);
        @(negedge clk);
        cyc++;
        imem_gnt    = ($urandom_range(99) < gnt_pct);
        stall       = ($urandom_range(99) < stall_pct);
        jump_flag   = jmp;
        jump_target = tgt;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (!mem_hold && mem_q.size() > 0 && mem_q[0].cyc < cyc && $urandom_range(99) < rsp_pct) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
        #1;
        if (jmp) begin
            chk("req_during_jump", {31'b0, imem_req}, 32'd0);
            exp_q.delete();
            next_pc = {tgt[31:2], 2'b00};
        end else if (hold_pending) begin
            chk("req_held_no_gnt", {31'b0, imem_req}, 32'd1);
            chk("addr_held_no_gnt", imem_addr, hold_addr);
        end
        hold_pending = 1'b0;
        if (imem_req) chk("imem_addr", imem_addr, next_pc);
        if (imem_req && imem_gnt) begin
            mem_q.push_back('{addr: imem_addr, cyc: cyc});
            exp_q.push_back('{pc: next_pc, inst: mem_word(next_pc)});
            next_pc = next_pc + 32'd4;
            if (first_acc < 0) first_acc = cyc;
        end else if (imem_req) begin
            hold_pending = 1'b1;
            hold_addr    = imem_addr;
        end
        if (inst_valid && first_val < 0) first_val = cyc;
    endtask

    // Monitor: compares every consumed head against the scoreboard.
    initial begin
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                if (inst_valid && !stall && !jump_flag) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_inst: got pc %h, required no pending fetch", inst_pc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("inst_pc", inst_pc, e.pc);
                        chk("inst", inst, e.inst);
                    end
                end else if (!inst_valid) begin
                    chk("bubble_inst", inst, NOP_BUBBLE);
                    chk("bubble_pc", inst_pc, 32'h0);
                end
            end
        end
    end

    initial begin
        logic        jmp;
        logic [31:0] tgt;
        reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        jump_flag = 1'b0; jump_target = '0; stall = 1'b0;
        gnt_pct = 100; stall_pct = 0; rsp_pct = 100; jmp_pct = 0; mem_hold = 1'b0;
        hold_pending = 1'b0; next_pc = RPC; cyc = 0; first_acc = -1; first_val = -1;
        #12;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, RPC);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_pc", inst_pc, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        repeat (10) step(1'b0, 32'h0);
        chk("first_latency", first_val - first_acc, 32'd2);

        stall_pct = 100;
        repeat (6) step(1'b0, 32'h0);
        chk("stall_full_req", {31'b0, imem_req}, 32'd0);
        chk("stall_full_valid", {31'b0, inst_valid}, 32'd1);
        stall_pct = 0;
        repeat (6) step(1'b0, 32'h0);

        gnt_pct = 0;
        repeat (3) step(1'b0, 32'h0);
        gnt_pct = 100;
        repeat (4) step(1'b0, 32'h0);

        mem_hold = 1'b1;
        repeat (2) step(1'b0, 32'h0);
        step(1'b1, 32'h100);
        mem_hold = 1'b0;
        repeat (8) step(1'b0, 32'h0);

        stall_pct = 100; mem_hold = 1'b1;
        repeat (3) step(1'b0, 32'h0);
        mem_hold = 1'b0;
        step(1'b1, 32'h203);
        step(1'b0, 32'h0);
        chk("flush_empty", {31'b0, inst_valid}, 32'd0);
        stall_pct = 0;
        repeat (8) step(1'b0, 32'h0);

        step(1'b1, 32'hFFFF_FFFA);
        repeat (8) step(1'b0, 32'h0);

        stall_pct = 100;
        repeat (4) step(1'b0, 32'h0);
        chk("pre_reset_valid", {31'b0, inst_valid}, 32'd1);
        #2;
        reset = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; jump_flag = 1'b0;
        #1;
        chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
        chk("mid_rst_addr", imem_addr, RPC);
        chk("mid_rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("mid_rst_inst", inst, 32'h0);
        chk("mid_rst_pc", inst_pc, 32'h0);
        mem_q.delete(); exp_q.delete(); next_pc = RPC; hold_pending = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        stall_pct = 0;
        repeat (6) step(1'b0, 32'h0);

        for (int p = 0; p < 4; p++) begin
            gnt_pct   = (p == 0) ? 90 : (p == 1) ? 60 : (p == 2) ? 100 : 40;
            stall_pct = (p == 0) ? 10 : (p == 1) ? 40 : (p == 2) ? 0   : 60;
            rsp_pct   = (p == 0) ? 80 : (p == 1) ? 50 : (p == 2) ? 100 : 30;
            jmp_pct   = (p == 3) ? 12 : 3;
            repeat (700) begin
                jmp = ($urandom_range(99) < jmp_pct);
                tgt = $urandom & 32'h0000_3FFF;
                if ($urandom_range(7) == 0) tgt = tgt | 32'hFFFF_FFF0;
                step(jmp, tgt);
            end
        end

        gnt_pct = 0; stall_pct = 0; rsp_pct = 100; mem_hold = 1'b0;
        repeat (12) step(1'b0, 32'h0);
        chk("drain_scoreboard", exp_q.size(), 32'd0);
        chk("drain_valid", {31'b0, inst_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
